uart_receiver: RTL and testbench

- Serial-to-parallel UART receive stage. It sits directly downstream of the UART transmitter and consumes its tx line: 1 start bit, 8 data bits LSB first, an optional parity bit, and 1 stop bit.
- It oversamples rx at 16x the baud rate and samples each bit at its centre.
- It presents each received byte with parity and framing status and holds it until the consumer reads it. It flags overrun if a byte is lost.

---
 rtl/uart_receiver.sv | 153 +++++++++++++++
 tb/tb_uart_receiver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled, centre-sampled 8-bit frames with optional parity,
// held output byte with parity/framing status and a sticky overrun flag.
module uart_receiver #(
    parameter bit PARITY_EN   = 1'b1,
    parameter bit PARITY_TYPE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick16,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state, state_next;
    logic                rx_m, rx_s;
    logic [CNT_W-1:0]    tick_cnt, tick_cnt_next;
    logic [IDX_W-1:0]    bit_idx, bit_idx_next;
    logic [DATA_W-1:0]   shift, shift_next;
    logic                perr, perr_next;
    logic                done_c;
    logic                ferr_c;

    // Two-flop synchronizer; line idles high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            perr     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            perr     <= perr_next;
            busy     <= (state_next != IDLE);
        end
    end

    // Next-state logic; everything advances only on a 16x tick
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        perr_next     = perr;
        done_c        = 1'b0;
        ferr_c        = 1'b0;
        if (baud_tick16) begin
            tick_cnt_next = CNT_W'(tick_cnt + 1'b1);
            case (state)
                IDLE: begin
                    tick_cnt_next = '0;
                    if (!rx_s) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (tick_cnt == 4'd7) begin
                        tick_cnt_next = '0;
                        if (!rx_s) begin
                            state_next   = DATA;
                            bit_idx_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick_cnt == 4'd15) begin
                        shift_next = {rx_s, shift[DATA_W-1:1]};
                        if (bit_idx == 3'd7) begin
                            state_next = PARITY_EN ? PARITY : STOP;
                        end else begin
                            bit_idx_next = IDX_W'(bit_idx + 1'b1);
                        end
                    end
                end
                PARITY: begin
                    if (tick_cnt == 4'd15) begin
                        // Mismatch against XOR (even) or XNOR (odd) of the data bits
                        perr_next  = rx_s ^ (^shift) ^ PARITY_TYPE;
                        state_next = STOP;
                    end
                end
                STOP: begin
                    if (tick_cnt == 4'd15) begin
                        ferr_c     = ~rx_s;
                        done_c     = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output holding registers and consumer handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done_c) begin
            data_out   <= shift;
            parity_err <= PARITY_EN & perr;
            frame_err  <= ferr_c;
            data_valid <= 1'b1;
            if (data_valid) begin
                overrun <= ~rd_en;
            end
        end else if (rd_en && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: even-parity, odd-parity and no-parity instances,
// each with its own rx/rd_en line; frames are checked when busy falls.
module tb_uart_receiver;

    localparam int BIT_CLK = 64;  // 16 ticks x 4 clk

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] tcnt;
    logic       tick;
    logic [2:0] rx_v;
    logic [2:0] rd_v;
    wire  [7:0] dout_v [3];
    wire  [2:0] dv_v, pe_v, fe_v, ov_v, busy_v;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    uart_receiver #(.PARITY_EN(1'b1), .PARITY_TYPE(1'b0)) u0 (
        .clk(clk), .rst(rst), .baud_tick16(tick), .rx(rx_v[0]), .rd_en(rd_v[0]),
        .data_out(dout_v[0]), .data_valid(dv_v[0]), .parity_err(pe_v[0]),
        .frame_err(fe_v[0]), .overrun(ov_v[0]), .busy(busy_v[0]));

    uart_receiver #(.PARITY_EN(1'b1), .PARITY_TYPE(1'b1)) u1 (
        .clk(clk), .rst(rst), .baud_tick16(tick), .rx(rx_v[1]), .rd_en(rd_v[1]),
        .data_out(dout_v[1]), .data_valid(dv_v[1]), .parity_err(pe_v[1]),
        .frame_err(fe_v[1]), .overrun(ov_v[1]), .busy(busy_v[1]));

    uart_receiver #(.PARITY_EN(1'b0), .PARITY_TYPE(1'b0)) u2 (
        .clk(clk), .rst(rst), .baud_tick16(tick), .rx(rx_v[2]), .rd_en(rd_v[2]),
        .data_out(dout_v[2]), .data_valid(dv_v[2]), .parity_err(pe_v[2]),
        .frame_err(fe_v[2]), .overrun(ov_v[2]), .busy(busy_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16x tick once every 4 clk
    always @(posedge clk or negedge rst) begin
        if (!rst) tcnt <= 2'd0;
        else      tcnt <= 2'(tcnt + 2'd1);
    end
    assign tick = (tcnt == 2'd3);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Completion monitor: a fall of busy with an expectation pending for that instance
    logic [2:0] busy_prev;
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (busy_prev[i] && !busy_v[i] && sb.size() > 0 && sb[0].sel == i) begin
                e = sb.pop_front();
                check("data_out",   32'(dout_v[i]), 32'(e.d));
                check("parity_err", 32'(pe_v[i]),   32'(e.p));
                check("frame_err",  32'(fe_v[i]),   32'(e.f));
                check("data_valid", 32'(dv_v[i]),   1);
            end
        end
        busy_prev <= busy_v;
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic line(input int sel, input logic v, input int n);
        rx_v[sel] = v;
        hold(n);
    endtask

    // One frame; parity bit only on the parity-enabled instances
    task automatic send(input int sel, input logic [7:0] b, input logic pbit, input logic stop_bit);
        exp_t e;
        e.sel = sel;
        e.d   = b;
        e.f   = ~stop_bit;
        if (sel == 0)      e.p = (pbit != ^b);
        else if (sel == 1) e.p = (pbit != ~^b);
        else               e.p = 1'b0;
        sb.push_back(e);
        line(sel, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) line(sel, b[i], BIT_CLK);
        if (sel != 2) line(sel, pbit, BIT_CLK);
        if (stop_bit) begin
            line(sel, 1'b1, BIT_CLK);
        end else begin
            line(sel, 1'b0, 48);
            line(sel, 1'b1, BIT_CLK - 48);
        end
    endtask

    task automatic read(input int sel);
        rd_v[sel] = 1'b1;
        hold(1);
        rd_v[sel] = 1'b0;
        check("rd_clr_dv", 32'(dv_v[sel]), 0);
        check("rd_clr_ov", 32'(ov_v[sel]), 0);
    endtask

    initial begin
        bit seen;
        int k;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        rx_v      = 3'b111;
        rd_v      = 3'b000;
        busy_prev = 3'b000;
        hold(5);
        check("rst_dout", 32'(dout_v[0]), 0);
        check("rst_dv",   32'(dv_v[0]),   0);
        check("rst_busy", 32'(busy_v[0]), 0);
        check("rst_ov",   32'(ov_v[0]),   0);
        rst = 1'b1;
        hold(2 * BIT_CLK);

        // Clean byte, even parity
        send(0, 8'hA5, 1'b0, 1'b1);
        check("a5_ov", 32'(ov_v[0]), 0);
        read(0);

        // Wrong even parity, then the same bits on the odd-parity instance
        send(0, 8'h3C, 1'b1, 1'b1);
        read(0);
        send(1, 8'h3C, 1'b1, 1'b1);
        read(1);

        // Framing error then a clean frame
        send(0, 8'h81, 1'b0, 1'b0);
        hold(2 * BIT_CLK);
        read(0);
        send(0, 8'h7E, 1'b0, 1'b1);
        read(0);

        // Back-to-back frames without a read: overrun
        send(0, 8'h11, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b1);
        check("ovr_data", 32'(dout_v[0]), 32'h22);
        check("ovr_dv",   32'(dv_v[0]),   1);
        check("ovr_flag", 32'(ov_v[0]),   1);
        read(0);

        // Read on the exact completion edge of the second frame
        send(0, 8'h11, 1'b0, 1'b1);
        fork
            send(0, 8'h22, 1'b0, 1'b1);
            begin
                k = 0;
                while (!u0.done_c && k < 12 * BIT_CLK) begin
                    hold(1);
                    k++;
                end
                check("rd_sync_found", 32'(u0.done_c), 1);
                rd_v[0] = 1'b1;
                hold(1);
                rd_v[0] = 1'b0;
            end
        join
        check("sync_dv",   32'(dv_v[0]),   1);
        check("sync_ov",   32'(ov_v[0]),   0);
        check("sync_data", 32'(dout_v[0]), 32'h22);
        read(0);

        // False start: rx low for 3 ticks
        rx_v[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            hold(1);
            if (busy_v[0]) seen = 1'b1;
        end
        rx_v[0] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            hold(1);
            if (busy_v[0]) seen = 1'b1;
        end
        check("glitch_busy_seen", 32'(seen), 1);
        check("glitch_busy_end",  32'(busy_v[0]), 0);
        check("glitch_dv",        32'(dv_v[0]), 0);

        // Reset during data bit 4 with a byte held
        send(0, 8'hA5, 1'b0, 1'b1);
        line(0, 1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) line(0, 1'b1, BIT_CLK);
        hold(BIT_CLK / 2);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_v[0]), 0);
        check("mid_rst_dv",   32'(dv_v[0]),   0);
        check("mid_rst_dout", 32'(dout_v[0]), 0);
        hold(2);
        rx_v[0] = 1'b1;
        rst = 1'b1;
        hold(2 * BIT_CLK);
        send(0, 8'h5A, 1'b0, 1'b1);
        read(0);

        // No-parity instance: 10-bit frames back to back
        send(2, 8'hFF, 1'b0, 1'b1);
        send(2, 8'h00, 1'b0, 1'b1);
        check("nopar_ov", 32'(ov_v[2]), 1);
        read(2);

        hold(BIT_CLK);
        check("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
